// File: rtl/ebm_session_ctrl.sv
// rtl/ebm_session_ctrl.sv - billing machine session sequencer
module ebm_session_ctrl #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] meter_number,
    input  logic        exit,
    input  logic        menu_valid,
    input  logic [2:0]  menu_option,
    input  logic [12:0] units_today,
    input  logic        pay_valid,
    input  logic [15:0] pay_amount,
    output logic        lk_req,
    output logic [11:0] lk_meter,
    input  logic        lk_ack,
    input  logic        lk_found,
    input  logic [3:0]  lk_index,
    output logic [3:0]  db_index,
    input  logic [12:0] db_prev_units,
    input  logic [4:0]  db_due_date,
    input  logic [3:0]  db_due_month,
    input  logic [12:0] db_due_year,
    output logic        db_wr_en,
    output logic [12:0] db_wr_units,
    output logic [4:0]  db_wr_date,
    output logic [3:0]  db_wr_month,
    output logic [12:0] db_wr_year,
    output logic [12:0] units_used,
    output logic        units_valid,
    output logic [15:0] amount,
    output logic        amount_valid,
    output logic [4:0]  nxt_due_date,
    output logic [3:0]  nxt_due_month,
    output logic [12:0] nxt_due_year,
    output logic        paid,
    output logic        error,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LOOKUP = 3'd1, S_MENU = 3'd2,
        S_UNITS = 3'd3, S_BILL = 3'd4, S_PAY = 3'd5
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        cur;
    logic [CW-1:0] idle_cnt;
    logic          bill_phase;
    logic          bill_rb;
    logic [12:0]   bill_c;

    // A reading below the stored one means the meter rolled back: bill nothing.
    logic        rollback;
    logic [12:0] cons;
    assign rollback = units_today < db_prev_units;
    assign cons     = rollback ? 13'd0 : units_today - db_prev_units;

    logic [15:0] t1, t2, t3, bill_amt;
    assign t1 = (bill_c > 13'd100) ? 16'd100 : {3'b0, bill_c};
    assign t2 = (bill_c > 13'd300) ? 16'd200 :
                (bill_c > 13'd100) ? {3'b0, bill_c - 13'd100} : 16'd0;
    assign t3 = (bill_c > 13'd300) ? {3'b0, bill_c - 13'd300} : 16'd0;
    assign bill_amt = (t1 << 1) + (t2 << 2) + t3 * 16'd6;

    logic [4:0]  nd_date;
    logic [3:0]  nd_month;
    logic [12:0] nd_year;
    assign nd_date  = (db_due_date > 5'd28) ? 5'd28 : db_due_date;
    assign nd_month = (db_due_month == 4'd12) ? 4'd1 : db_due_month + 4'd1;
    assign nd_year  = (db_due_month == 4'd12) ? db_due_year + 13'd1 : db_due_year;

    logic quiet, timeout_hit, to_idle;
    assign quiet       = !menu_valid && !pay_valid;
    assign timeout_hit = idle_cnt == CW'(TIMEOUT - 1);
    assign to_idle = (cur != S_IDLE) && (exit ||
                     (cur == S_MENU && menu_valid && menu_option == 3'd0) ||
                     ((cur == S_MENU || cur == S_PAY) && quiet && timeout_hit));

    assign state = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= S_IDLE;           idle_cnt <= '0;
            bill_phase <= 1'b0;      bill_rb <= 1'b0;       bill_c <= '0;
            lk_req <= 1'b0;          lk_meter <= '0;        db_index <= '0;
            db_wr_en <= 1'b0;        db_wr_units <= '0;     db_wr_date <= '0;
            db_wr_month <= '0;       db_wr_year <= '0;
            units_used <= '0;        units_valid <= 1'b0;
            amount <= '0;            amount_valid <= 1'b0;
            nxt_due_date <= '0;      nxt_due_month <= '0;   nxt_due_year <= '0;
            paid <= 1'b0;            error <= 1'b0;
        end else begin
            units_valid <= 1'b0;
            db_wr_en    <= 1'b0;
            paid        <= 1'b0;
            error       <= 1'b0;
            lk_req      <= 1'b0;
            idle_cnt    <= '0;
            if (exit && cur != S_IDLE) begin
                cur <= S_IDLE;
            end else begin
                case (cur)
                    S_IDLE: if (start) begin
                        lk_meter <= meter_number;
                        lk_req   <= 1'b1;
                        cur      <= S_LOOKUP;
                    end
                    S_LOOKUP: begin
                        if (!lk_ack) begin
                            lk_req <= 1'b1;
                        end else if (lk_found) begin
                            db_index <= lk_index;
                            cur      <= S_MENU;
                        end else begin
                            error <= 1'b1;
                            cur   <= S_IDLE;
                        end
                    end
                    S_MENU: begin
                        if (menu_valid) begin
                            case (menu_option)
                                3'd0: cur <= S_IDLE;
                                3'd1: cur <= S_UNITS;
                                3'd2: cur <= S_BILL;
                                3'd3: if (amount_valid) cur <= S_PAY;
                                      else error <= 1'b1;
                                default: ;
                            endcase
                        end else if (quiet) begin
                            if (timeout_hit) cur <= S_IDLE;
                            else idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                    S_UNITS: begin
                        units_used  <= cons;
                        units_valid <= 1'b1;
                        error       <= rollback;
                        cur         <= S_MENU;
                    end
                    S_BILL: begin
                        bill_phase <= !bill_phase;
                        if (!bill_phase) begin
                            bill_c  <= cons;
                            bill_rb <= rollback;
                        end else begin
                            amount       <= bill_amt;
                            amount_valid <= 1'b1;
                            error        <= bill_rb;
                            cur          <= S_MENU;
                        end
                    end
                    S_PAY: begin
                        if (pay_valid) begin
                            if (pay_amount >= amount) begin
                                db_wr_en      <= 1'b1;
                                db_wr_units   <= units_today;
                                db_wr_date    <= nd_date;
                                db_wr_month   <= nd_month;
                                db_wr_year    <= nd_year;
                                nxt_due_date  <= nd_date;
                                nxt_due_month <= nd_month;
                                nxt_due_year  <= nd_year;
                                paid          <= 1'b1;
                                amount_valid  <= 1'b0;
                                cur           <= S_MENU;
                            end else begin
                                error <= 1'b1;
                            end
                        end else if (quiet) begin
                            if (timeout_hit) cur <= S_IDLE;
                            else idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                    default: cur <= S_IDLE;
                endcase
            end
            // The bill is per-session: drop it whenever the session ends.
            if (to_idle) begin
                amount       <= '0;
                amount_valid <= 1'b0;
                bill_phase   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ebm_session_ctrl.sv
// tb/tb_ebm_session_ctrl.sv - directed bench for ebm_session_ctrl
module tb_ebm_session_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, exit = 1'b0, menu_valid = 1'b0, pay_valid = 1'b0;
    logic [11:0] meter_number = '0;
    logic [2:0]  menu_option = '0;
    logic [12:0] units_today = '0;
    logic [15:0] pay_amount = '0;
    logic        lk_req, lk_ack = 1'b0, lk_found = 1'b0;
    logic [11:0] lk_meter;
    logic [3:0]  lk_index = '0, db_index;
    logic [12:0] db_prev_units = '0, db_due_year = '0;
    logic [4:0]  db_due_date = '0;
    logic [3:0]  db_due_month = '0;
    logic        db_wr_en, units_valid, amount_valid, paid, error;
    logic [12:0] db_wr_units, db_wr_year, units_used, nxt_due_year;
    logic [4:0]  db_wr_date, nxt_due_date;
    logic [3:0]  db_wr_month, nxt_due_month;
    logic [15:0] amount;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    ebm_session_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .meter_number(meter_number),
        .exit(exit), .menu_valid(menu_valid), .menu_option(menu_option),
        .units_today(units_today), .pay_valid(pay_valid), .pay_amount(pay_amount),
        .lk_req(lk_req), .lk_meter(lk_meter), .lk_ack(lk_ack), .lk_found(lk_found),
        .lk_index(lk_index), .db_index(db_index), .db_prev_units(db_prev_units),
        .db_due_date(db_due_date), .db_due_month(db_due_month), .db_due_year(db_due_year),
        .db_wr_en(db_wr_en), .db_wr_units(db_wr_units), .db_wr_date(db_wr_date),
        .db_wr_month(db_wr_month), .db_wr_year(db_wr_year), .units_used(units_used),
        .units_valid(units_valid), .amount(amount), .amount_valid(amount_valid),
        .nxt_due_date(nxt_due_date), .nxt_due_month(nxt_due_month),
        .nxt_due_year(nxt_due_year), .paid(paid), .error(error), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic login(input logic [11:0] meter, input logic [3:0] idx);
        meter_number = meter; start = 1'b1;
        tick();
        start = 1'b0;
        lk_ack = 1'b1; lk_found = 1'b1; lk_index = idx;
        tick();
        lk_ack = 1'b0; lk_found = 1'b0;
    endtask

    task automatic menu(input logic [2:0] opt);
        menu_valid = 1'b1; menu_option = opt;
        tick();
        menu_valid = 1'b0;
    endtask

    task automatic pay(input logic [15:0] amt);
        pay_valid = 1'b1; pay_amount = amt;
        tick();
        pay_valid = 1'b0;
    endtask

    task automatic set_db(input logic [12:0] prev, input logic [4:0] d,
                          input logic [3:0] m, input logic [12:0] y);
        db_prev_units = prev; db_due_date = d; db_due_month = m; db_due_year = y;
    endtask

    task automatic bill(input logic [15:0] exp_amt, input logic exp_err);
        menu(3'd2);
        tick();
        chk("bill_mid_state", 32'(state), 32'd4);
        tick();
        chk("bill_amount", 32'(amount), 32'(exp_amt));
        chk("bill_valid", 32'(amount_valid), 32'd1);
        chk("bill_err", 32'(error), 32'(exp_err));
    endtask

    initial begin
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_lk_req", 32'(lk_req), 32'd0);
        chk("rst_amount", 32'(amount), 32'd0);
        rst_n = 1'b1;
        tick();

        // Main session: meter 1003
        set_db(13'd400, 5'd27, 4'd4, 13'd2023);
        units_today = 13'd750;
        meter_number = 12'd1003; start = 1'b1;
        tick();
        start = 1'b0;
        chk("lk_state", 32'(state), 32'd1);
        chk("lk_req_hi", 32'(lk_req), 32'd1);
        chk("lk_meter", 32'(lk_meter), 32'd1003);
        tick();
        chk("lk_wait", 32'(lk_req), 32'd1);
        lk_ack = 1'b1; lk_found = 1'b1; lk_index = 4'd3;
        tick();
        lk_ack = 1'b0; lk_found = 1'b0;
        chk("menu_state", 32'(state), 32'd2);
        chk("lk_req_lo", 32'(lk_req), 32'd0);
        chk("db_index", 32'(db_index), 32'd3);

        menu(3'd3);
        chk("pay_nobill_err", 32'(error), 32'd1);
        chk("pay_nobill_state", 32'(state), 32'd2);

        lk_ack = 1'b1;
        tick();
        lk_ack = 1'b0;
        chk("stray_ack_err", 32'(error), 32'd0);
        chk("stray_ack_state", 32'(state), 32'd2);

        menu(3'd1);
        chk("units_state", 32'(state), 32'd3);
        tick();
        chk("units_valid", 32'(units_valid), 32'd1);
        chk("units_used", 32'(units_used), 32'd350);
        chk("units_err", 32'(error), 32'd0);

        bill(16'd1300, 1'b0);
        menu(3'd3);
        chk("pay_state", 32'(state), 32'd5);
        pay(16'd1299);
        chk("under_err", 32'(error), 32'd1);
        chk("under_wr", 32'(db_wr_en), 32'd0);
        chk("under_state", 32'(state), 32'd5);
        pay(16'd1300);
        chk("pay_wr", 32'(db_wr_en), 32'd1);
        chk("pay_paid", 32'(paid), 32'd1);
        chk("pay_wr_units", 32'(db_wr_units), 32'd750);
        chk("pay_wr_date", 32'(db_wr_date), 32'd27);
        chk("pay_wr_month", 32'(db_wr_month), 32'd5);
        chk("pay_wr_year", 32'(db_wr_year), 32'd2023);
        chk("pay_avalid", 32'(amount_valid), 32'd0);
        chk("pay_back_menu", 32'(state), 32'd2);
        tick();
        chk("wr_one_cycle", 32'(db_wr_en), 32'd0);
        chk("paid_one_cycle", 32'(paid), 32'd0);

        // Year wrap plus date clamp, then plain month step
        set_db(13'd400, 5'd30, 4'd12, 13'd2023);
        bill(16'd1300, 1'b0);
        menu(3'd3);
        pay(16'd2000);
        chk("wrap_date", 32'(nxt_due_date), 32'd28);
        chk("wrap_month", 32'(nxt_due_month), 32'd1);
        chk("wrap_year", 32'(nxt_due_year), 32'd2024);
        set_db(13'd400, 5'd4, 4'd1, 13'd2023);
        bill(16'd1300, 1'b0);
        menu(3'd3);
        pay(16'd1300);
        chk("step_date", 32'(nxt_due_date), 32'd4);
        chk("step_month", 32'(nxt_due_month), 32'd2);
        chk("step_year", 32'(nxt_due_year), 32'd2023);

        // Rollback: reading below stored units
        set_db(13'd500, 5'd10, 4'd6, 13'd2023);
        units_today = 13'd300;
        menu(3'd1);
        tick();
        chk("rb_units_valid", 32'(units_valid), 32'd1);
        chk("rb_units_used", 32'(units_used), 32'd0);
        chk("rb_units_err", 32'(error), 32'd1);
        bill(16'd0, 1'b1);
        menu(3'd3);
        pay(16'd0);
        chk("rb_pay_zero", 32'(paid), 32'd1);
        chk("rb_wr_units", 32'(db_wr_units), 32'd300);

        // exit wins over a simultaneous valid payment
        set_db(13'd400, 5'd27, 4'd4, 13'd2023);
        units_today = 13'd750;
        bill(16'd1300, 1'b0);
        menu(3'd3);
        exit = 1'b1;
        pay(16'd5000);
        exit = 1'b0;
        chk("exit_state", 32'(state), 32'd0);
        chk("exit_wr", 32'(db_wr_en), 32'd0);
        chk("exit_paid", 32'(paid), 32'd0);
        chk("exit_err", 32'(error), 32'd0);
        chk("exit_avalid", 32'(amount_valid), 32'd0);

        // Lookup miss
        meter_number = 12'd7; start = 1'b1;
        tick();
        start = 1'b0;
        lk_ack = 1'b1; lk_found = 1'b0;
        tick();
        lk_ack = 1'b0;
        chk("miss_err", 32'(error), 32'd1);
        chk("miss_state", 32'(state), 32'd0);
        chk("miss_lk_req", 32'(lk_req), 32'd0);

        // Idle timeout: 15 quiet cycles in MENU
        login(12'd1003, 4'd3);
        chk("to_enter", 32'(state), 32'd2);
        for (int i = 0; i < 14; i++) tick();
        chk("to_before", 32'(state), 32'd2);
        tick();
        chk("to_after", 32'(state), 32'd0);

        // Asynchronous reset in the middle of BILL
        login(12'd1003, 4'd3);
        menu(3'd2);
        chk("bill_entered", 32'(state), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_lk_meter", 32'(lk_meter), 32'd0);
        chk("arst_db_index", 32'(db_index), 32'd0);
        chk("arst_nxt_year", 32'(nxt_due_year), 32'd0);
        chk("arst_wr_units", 32'(db_wr_units), 32'd0);
        chk("arst_units_used", 32'(units_used), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
